// File: rtl/sram_line_controller.sv
// sram_line_controller
// Line-fill / write-back sequencer that sits in front of a single-port word SRAM.
// Each cache-line request becomes WORDS_PER_LINE back-to-back word accesses.
// Read words are gathered into a line, and one response pulse is returned per request.
// Optional feature macro: MEM_CTRL_CRITICAL_WORD_FIRST_EN. When it is defined,
// reads start at the requested word and the critical word is forwarded early
// on rsp_crit_valid/rsp_crit_data.
module sram_line_controller #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_we,
    input  logic [ADDR_W-1:0]                req_addr,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] req_wdata,
    output logic                             rsp_valid,
    output logic [WORDS_PER_LINE*DATA_W-1:0] rsp_rdata,
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    output logic                             rsp_crit_valid,
    output logic [DATA_W-1:0]                rsp_crit_data,
`endif
    output logic [ADDR_W-1:0]                sram_a,
    output logic [DATA_W-1:0]                sram_d,
    output logic                             sram_we,
    output logic                             sram_csb,
    input  logic [DATA_W-1:0]                sram_q
);

    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        DRAIN,
        RESP
    } state_t;

    state_t                     state_q;
    logic [OFF_W-1:0]           cnt_q;
    logic [ADDR_W-OFF_W-1:0]    base_q;
    logic [LINE_W-DATA_W-1:0]   wdata_q;
    logic [LINE_W-1:0]          line_q;
    logic                       pend_q;
    logic [OFF_W-1:0]           pend_slot_q;
    logic                       ready_q;
    logic                       rsp_valid_q;
    logic [LINE_W-1:0]          rsp_rdata_q;
    logic [ADDR_W-1:0]          sram_a_q;
    logic [DATA_W-1:0]          sram_d_q;
    logic                       sram_we_q;
    logic                       sram_csb_q;

    logic                       accept_d;
    logic [OFF_W-1:0]           cnt_d;
    logic [OFF_W-1:0]           first_slot_d;
    logic [OFF_W-1:0]           cur_slot_d;
    logic [OFF_W-1:0]           next_slot_d;
    logic [DATA_W-1:0]          wr_next_word_d;
    logic [LINE_W-1:0]          line_d;

`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    logic [OFF_W-1:0]           off_q;
    logic                       crit_pend_q;
`else
    // Offset bits only matter for critical-word-first ordering.
    logic                       unused_offset_bits;
    assign unused_offset_bits = ^req_addr[OFF_W-1:0];
`endif

    // Next word slot, write data selection and read-line merge.
    always_comb begin
        accept_d = (state_q == IDLE) && ready_q && req_valid;
        cnt_d    = cnt_q + 1'b1;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
        first_slot_d = req_addr[OFF_W-1:0];
        cur_slot_d   = off_q + cnt_q;
        next_slot_d  = off_q + cnt_d;
`else
        first_slot_d = '0;
        cur_slot_d   = cnt_q;
        next_slot_d  = cnt_d;
`endif
        // Word 0 goes out straight from the request, so only words 1.. are stored.
        wr_next_word_d = '0;
        if (cnt_d != '0) begin
            wr_next_word_d = wdata_q[(int'(cnt_d) - 1) * DATA_W +: DATA_W];
        end
        line_d = line_q;
        if (pend_q) begin
            line_d[int'(pend_slot_q) * DATA_W +: DATA_W] = sram_q;
        end
    end

    // Sequencer FSM with registered SRAM strobes, ready and response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            pend_q      <= 1'b0;
            pend_slot_q <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            sram_a_q    <= '0;
            sram_d_q    <= '0;
            sram_we_q   <= 1'b1;
            sram_csb_q  <= 1'b1;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
            off_q       <= '0;
            crit_pend_q <= 1'b0;
`endif
        end else begin
            pend_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
            crit_pend_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        ready_q    <= 1'b0;
                        cnt_q      <= '0;
                        base_q     <= req_addr[ADDR_W-1:OFF_W];
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
                        off_q      <= req_addr[OFF_W-1:0];
`endif
                        sram_csb_q <= 1'b0;
                        if (req_we) begin
                            state_q   <= WR;
                            sram_we_q <= 1'b0;
                            sram_a_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            sram_d_q  <= req_wdata[DATA_W-1:0];
                        end else begin
                            state_q   <= RD;
                            sram_we_q <= 1'b1;
                            sram_a_q  <= {req_addr[ADDR_W-1:OFF_W], first_slot_d};
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WR: begin
                    if (cnt_q == LAST_WORD) begin
                        state_q     <= RESP;
                        sram_csb_q  <= 1'b1;
                        sram_we_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_d;
                        sram_a_q <= {base_q, cnt_d};
                        sram_d_q <= wr_next_word_d;
                    end
                end
                RD: begin
                    // The word addressed this cycle returns on sram_q next cycle.
                    pend_q      <= 1'b1;
                    pend_slot_q <= cur_slot_d;
`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
                    crit_pend_q <= (cnt_q == '0);
`endif
                    if (cnt_q == LAST_WORD) begin
                        state_q    <= DRAIN;
                        sram_csb_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_d;
                        sram_a_q <= {base_q, next_slot_d};
                    end
                end
                DRAIN: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= line_d;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Line payload storage; no reset needed, it is always written before use.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            wdata_q <= req_wdata[LINE_W-1:DATA_W];
        end
        if (pend_q) begin
            line_q <= line_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign sram_a    = sram_a_q;
    assign sram_d    = sram_d_q;
    assign sram_we   = sram_we_q;
    assign sram_csb  = sram_csb_q;

`ifdef MEM_CTRL_CRITICAL_WORD_FIRST_EN
    // The critical word is forwarded straight from the SRAM output in the cycle it arrives.
    assign rsp_crit_valid = crit_pend_q;
    assign rsp_crit_data  = crit_pend_q ? sram_q : '0;
`endif

endmodule
